// File: rtl/risc_mem_if.sv
// -----------------------------------------------------------------------------
// risc_mem_if
//   Bus between the accumulator control unit and its 16x8 synchronous memory.
//
//   mem_r        read strobe; memory presents M[mem_address] on mem_dataOut
//                in the following cycle
//   mem_w        write strobe; M[mem_address] <= mem_dataIn on the rising edge
//   mem_address  4-bit word address
//   mem_dataIn   write data towards memory
//   mem_dataOut  registered read data from memory
//
//   master : the control unit (drives strobes, address and write data)
//   slave  : the memory (drives read data)
// -----------------------------------------------------------------------------
interface risc_mem_if;
    logic       mem_r;
    logic       mem_w;
    logic [3:0] mem_address;
    logic [7:0] mem_dataIn;
    logic [7:0] mem_dataOut;

    modport master (
        output mem_r,
        output mem_w,
        output mem_address,
        output mem_dataIn,
        input  mem_dataOut
    );

    modport slave (
        input  mem_r,
        input  mem_w,
        input  mem_address,
        input  mem_dataIn,
        output mem_dataOut
    );
endinterface : risc_mem_if

// File: rtl/risc_control_unit.sv
// -----------------------------------------------------------------------------
// risc_control_unit
//   Multi-cycle control unit for a tiny accumulator machine. Each instruction
//   is fetched from a 16x8 synchronous memory, latched into IR, then executed.
//
//   Instruction: [7:6] opcode, [5] sub-op, [4] ignored, [3:0] operand address A
//     00 ADD   AC <= AC + M[A], carry <= carry-out
//     01 LOAD  AC <= M[A]
//     10 STORE M[A] <= AC
//     11 [5]=0 JMP  PC <= A
//     11 [5]=1 HALT (absorbing until reset)
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     run     start/continue enable, looked at only in FETCH
//     mem     memory bus (master side of risc_mem_if)
//     ac      accumulator
//     pc      program counter
//     carry   carry out of the last ADD
//     halted  high while in HALT
//
//   Cycle flow: FETCH -> LATCH -> EXEC (-> WB for ADD/LOAD) -> FETCH.
//   ADD/LOAD take 4 cycles, STORE/JMP take 3.
// -----------------------------------------------------------------------------
module risc_control_unit #(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    risc_mem_if.master        mem,
    output logic [7:0]        ac,
    output logic [3:0]        pc,
    output logic              carry,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_LOAD,
        OP_STORE,
        OP_JMP,
        OP_HALT
    } op_e;

    state_e     state_q, state_d;
    logic [3:0] pc_q,    pc_d;
    logic [7:0] ac_q,    ac_d;
    logic       carry_q, carry_d;
    logic [7:0] ir_q,    ir_d;

    op_e        op;
    logic [3:0] operand;
    logic [8:0] sum;

    logic       rd_strobe;
    logic       wr_strobe;
    logic [3:0] addr;

    // -------------------------------------------------------------------------
    // Instruction decode from the latched IR. Bit 4 is a don't-care.
    // -------------------------------------------------------------------------
    assign operand = ir_q[3:0];

    always_comb begin
        op = OP_ADD;
        casez (ir_q[7:4])
            4'b00??: op = OP_ADD;
            4'b01??: op = OP_LOAD;
            4'b10??: op = OP_STORE;
            4'b110?: op = OP_JMP;
            4'b111?: op = OP_HALT;
            default: op = OP_ADD;
        endcase
    end

    // 9-bit sum so the carry-out is simply the top bit.
    assign sum = {1'b0, ac_q} + {1'b0, mem.mem_dataOut};

    // -------------------------------------------------------------------------
    // Next-state and strobe decode. Strobes depend only on registered state,
    // IR and run; mem_dataOut only feeds register next-values.
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path through
    // the case statements leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ac_d      = ac_q;
        carry_d   = carry_q;
        ir_d      = ir_q;
        rd_strobe = 1'b0;
        wr_strobe = 1'b0;
        addr      = pc_q;

        unique case (state_q)
            S_FETCH: begin
                if (run) begin
                    rd_strobe = 1'b1;
                    state_d   = S_LATCH;
                end
            end

            S_LATCH: begin
                // Memory presents the fetched word this cycle.
                ir_d    = mem.mem_dataOut;
                pc_d    = pc_q + 4'd1;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                unique case (op)
                    OP_ADD, OP_LOAD: begin
                        rd_strobe = 1'b1;
                        addr      = operand;
                        state_d   = S_WB;
                    end
                    OP_STORE: begin
                        wr_strobe = 1'b1;
                        addr      = operand;
                        state_d   = S_FETCH;
                    end
                    OP_JMP: begin
                        // Replaces the incremented PC written in LATCH.
                        pc_d    = operand;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_WB: begin
                // Only ADD and LOAD reach WB.
                if (op == OP_ADD) begin
                    ac_d    = sum[7:0];
                    carry_d = sum[8];
                end else begin
                    ac_d = mem.mem_dataOut;
                end
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before this edge, independent of statement order.
    // NOTE: IR is reset along with the other registers; it is a single control
    // register, not a storage array, so the reset costs nothing meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ac_q    <= 8'h00;
            carry_q <= 1'b0;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            carry_q <= carry_d;
            ir_q    <= ir_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Strobes are gated by rst_n so they are quiet for the whole time
    // reset is held (FETCH with run=1 would otherwise show a read strobe), and
    // an in-flight write drops as soon as reset asserts.
    // -------------------------------------------------------------------------
    assign mem.mem_r       = rd_strobe & rst_n;
    assign mem.mem_w       = wr_strobe & rst_n;
    assign mem.mem_address = addr;
    assign mem.mem_dataIn  = ac_q;

    assign ac     = ac_q;
    assign pc     = pc_q;
    assign carry  = carry_q;
    assign halted = (state_q == S_HALT);

endmodule : risc_control_unit

// File: tb/tb_risc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_risc_control_unit
//   Directed programs run on a behavioural 16x8 synchronous memory. Each test
//   queues the bus transactions it expects; a monitor pops and compares one
//   entry for every cycle the DUT drives a strobe. Architectural state is
//   compared against hand-computed values at the end of each program.
// -----------------------------------------------------------------------------
module tb_risc_control_unit;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       run   = 1'b0;
    logic [7:0] ac;
    logic [3:0] pc;
    logic       carry;
    logic       halted;

    risc_mem_if bus ();

    risc_control_unit #(.RESET_PC(4'd0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .mem    (bus),
        .ac     (ac),
        .pc     (pc),
        .carry  (carry),
        .halted (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
    } bus_t;

    bus_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         pop_n    = 0;
    int         stamps[32];
    logic [7:0] ac_at[32];
    logic [7:0] mem[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous memory: read data appears the cycle after mem_r.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_r) bus.mem_dataOut <= mem[bus.mem_address];
        if (bus.mem_w) mem[bus.mem_address] = bus.mem_dataIn;
    end

    // Monitor: one scoreboard entry per strobe cycle.
    always @(negedge clk) begin : monitor
        bus_t e;
        if (rst_n && (bus.mem_r || bus.mem_w)) begin
            check("strobe_exclusive", 32'(bus.mem_r & bus.mem_w), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: r=%0b w=%0b addr=%0h with no transaction expected",
                         bus.mem_r, bus.mem_w, bus.mem_address);
            end else begin
                e = sb.pop_front();
                check("bus_dir",  32'(bus.mem_w),       32'(e.wr));
                check("bus_addr", 32'(bus.mem_address), 32'(e.addr));
                if (e.wr) check("bus_wdata", 32'(bus.mem_dataIn), 32'(e.data));
                if (pop_n < 32) begin
                    stamps[pop_n] = cyc;
                    ac_at[pop_n]  = ac;
                end
                pop_n++;
            end
        end
    end

    task automatic rd(input logic [3:0] a);
        sb.push_back(bus_t'{wr: 1'b0, addr: a, data: 8'h00});
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        sb.push_back(bus_t'{wr: 1'b1, addr: a, data: d});
    endtask

    // Hold reset, clear memory and scoreboard. Caller loads the program.
    task automatic reset_dut();
        @(posedge clk);
        #1;
        run   = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        pop_n = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_and_run();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 run = 1'b1;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (halted) break;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic wait_pops(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (pop_n >= n) break;
        end
        check("pops_reached", 32'(pop_n >= n), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int good;

        // ---- Reset values while rst_n is low, even with run high ----
        rst_n = 1'b0;
        run   = 1'b1;
        #12;
        check("rst_pc",     32'(pc),          32'h0);
        check("rst_ac",     32'(ac),          32'h0);
        check("rst_carry",  32'(carry),       32'h0);
        check("rst_halted", 32'(halted),      32'h0);
        check("rst_mem_r",  32'(bus.mem_r),   32'h0);
        check("rst_mem_w",  32'(bus.mem_w),   32'h0);

        // ---- Program A: LOAD/ADD carry/STORE/JMP/HALT and latencies ----
        reset_dut();
        mem[0] = 8'h4E;  // LOAD E  -> ac=FF
        mem[1] = 8'h0F;  // ADD F   -> FF+01 = 00, carry 1
        mem[2] = 8'h8D;  // STORE D -> M[D]=00
        mem[3] = 8'h4C;  // LOAD C  -> ac=5A
        mem[4] = 8'h8F;  // STORE F -> M[F]=5A
        mem[5] = 8'h4F;  // LOAD F  -> ac=5A, carry kept
        mem[6] = 8'hC9;  // JMP 9
        mem[9] = 8'hE0;  // HALT
        mem[12] = 8'h5A;
        mem[13] = 8'h33;
        mem[14] = 8'hFF;
        mem[15] = 8'h01;
        rd(4'h0); rd(4'hE); rd(4'h1); rd(4'hF); rd(4'h2); wr(4'hD, 8'h00);
        rd(4'h3); rd(4'hC); rd(4'h4); wr(4'hF, 8'h5A); rd(4'h5); rd(4'hF);
        rd(4'h6); rd(4'h9);
        release_and_run();
        wait_halt(200);
        check("A_ac",         32'(ac),      32'h5A);
        check("A_carry",      32'(carry),   32'h1);
        check("A_pc",         32'(pc),      32'hA);
        check("A_memD",       32'(mem[13]), 32'h00);
        check("A_memF",       32'(mem[15]), 32'h5A);
        check("A_ac_after_add", 32'(ac_at[4]), 32'h00);
        check("A_add_cycles",   stamps[4]  - stamps[2],  32'd4);
        check("A_store_cycles", stamps[6]  - stamps[4],  32'd3);
        check("A_jmp_cycles",   stamps[13] - stamps[12], 32'd3);
        good = 0;
        repeat (20) begin
            @(negedge clk);
            if (halted && !bus.mem_r && !bus.mem_w) good++;
        end
        check("A_halt_hold_cycles", 32'(good), 32'd20);
        check("A_sb_drained", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("A_rst_pc",     32'(pc),     32'h0);
        check("A_rst_halted", 32'(halted), 32'h0);

        // ---- Program B: LOAD then instruction words reused as data ----
        reset_dut();
        mem[0] = 8'h41;  // LOAD 1 -> ac=01
        mem[1] = 8'h01;  // ADD 1  -> ac=02
        mem[2] = 8'h02;  // ADD 2  -> ac=04
        mem[3] = 8'hE0;  // HALT
        rd(4'h0); rd(4'h1); rd(4'h1); rd(4'h1); rd(4'h2); rd(4'h2); rd(4'h3);
        release_and_run();
        wait_halt(100);
        check("B_ac_at_fetch1", 32'(ac_at[2]), 32'h01);
        check("B_ac",           32'(ac),       32'h04);
        check("B_carry",        32'(carry),    32'h0);
        check("B_pc",           32'(pc),       32'h4);
        check("B_sb_drained",   32'(sb.size()), 32'd0);

        // ---- Program C: run=0 idle, run dropped mid-instruction, JMP at 15 ----
        reset_dut();
        mem[0]  = 8'hCF;  // JMP F
        mem[15] = 8'hC3;  // JMP 3
        mem[3]  = 8'hE0;  // HALT
        rd(4'h0); rd(4'hF); rd(4'h3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("C_idle_pc",   32'(pc),    32'h0);
        check("C_idle_pops", 32'(pop_n), 32'd0);
        @(posedge clk);
        #1 run = 1'b1;
        wait_pops(1, 20);
        @(posedge clk);
        #1 run = 1'b0;
        repeat (6) @(negedge clk);
        check("C_jmp_done_pc", 32'(pc),    32'hF);
        check("C_held_pops",   32'(pop_n), 32'd1);
        @(posedge clk);
        #1 run = 1'b1;
        wait_halt(100);
        check("C_pc",         32'(pc),        32'h4);
        check("C_sb_drained", 32'(sb.size()), 32'd0);

        // ---- Program D: non-jump at 15 wraps to 0, self-modified word ----
        reset_dut();
        mem[0]  = 8'h4E;  // LOAD E -> ac=E0
        mem[1]  = 8'hCF;  // JMP F
        mem[15] = 8'h80;  // STORE 0 -> M[0]=E0 (HALT)
        mem[14] = 8'hE0;
        rd(4'h0); rd(4'hE); rd(4'h1); rd(4'hF); wr(4'h0, 8'hE0); rd(4'h0);
        release_and_run();
        wait_halt(100);
        check("D_ac",         32'(ac),        32'hE0);
        check("D_pc",         32'(pc),        32'h1);
        check("D_mem0",       32'(mem[0]),    32'hE0);
        check("D_sb_drained", 32'(sb.size()), 32'd0);

        // ---- Program E: reset asserted during STORE execute ----
        reset_dut();
        mem[0]  = 8'h4E;  // LOAD E -> ac=5A
        mem[1]  = 8'h8F;  // STORE F
        mem[14] = 8'h5A;
        mem[15] = 8'h11;
        rd(4'h0); rd(4'hE); rd(4'h1); wr(4'hF, 8'h5A);
        release_and_run();
        wait_pops(4, 50);
        check("E_store_active", 32'(bus.mem_w), 32'h1);
        rst_n = 1'b0;
        #1;
        check("E_mem_w_dropped", 32'(bus.mem_w), 32'h0);
        check("E_mem_r",         32'(bus.mem_r), 32'h0);
        check("E_pc",            32'(pc),        32'h0);
        check("E_ac",            32'(ac),        32'h0);
        check("E_carry",         32'(carry),     32'h0);
        check("E_halted",        32'(halted),    32'h0);
        @(posedge clk);
        #1;
        check("E_memF_untouched", 32'(mem[15]), 32'h11);
        check("E_pc_hold",        32'(pc),      32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_risc_control_unit
